// File: rtl/gpr_pkg.sv
// Shared widths, writeback payload and grant encoding for the GPR writeback path.
package gpr_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned NREG   = 32'(1) << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } grant_t;

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register pending bits: set on issue, cleared on register-file commit.
module gpr_scoreboard #(
  parameter int unsigned ADDR_W = gpr_pkg::ADDR_W,
  parameter int unsigned NREG   = gpr_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] chk_addr_1,
  input  logic [ADDR_W-1:0] chk_addr_2,
  output logic              chk_hit_1_c,
  output logic              chk_hit_2_c,
  output logic [NREG-1:0]   pending
);

  logic [NREG-1:0] pending_nxt;

  // Next pending vector: clear first so a same-cycle set on the same bit wins
  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt[clr_addr] = 1'b0;
    if (set_en) pending_nxt[set_addr] = 1'b1;
  end

  // Pending register
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  // Source-operand hazard lookups
  always_comb begin
    chk_hit_1_c = pending[chk_addr_1];
    chk_hit_2_c = pending[chk_addr_2];
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Round-robin writeback arbiter for the GPR write port plus hazard scoreboard.
module gpr_wb_arbiter #(
  parameter int unsigned DATA_W = gpr_pkg::DATA_W,
  parameter int unsigned ADDR_W = gpr_pkg::ADDR_W,
  parameter int unsigned NREG   = gpr_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              issue_conflict,
  input  logic [ADDR_W-1:0] chk_addr_1,
  input  logic [ADDR_W-1:0] chk_addr_2,
  output logic              stall,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_dest,
  output logic [DATA_W-1:0] write_data,
  output logic [NREG-1:0]   pending
);

  import gpr_pkg::grant_t;
  import gpr_pkg::GNT_ALU;
  import gpr_pkg::GNT_MEM;

  grant_t            last_grant;
  logic              xfer_c;
  logic [ADDR_W-1:0] win_dest_c;
  logic [DATA_W-1:0] win_data_c;
  logic              hit_1_c;
  logic              hit_2_c;

  // Grant: a lone requester wins; on a tie the producer not granted last wins
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (alu_valid && (!mem_valid || (last_grant == GNT_MEM))) alu_ready = 1'b1;
    else if (mem_valid)                                         mem_ready = 1'b1;
  end

  // Winning payload mux
  always_comb begin
    xfer_c     = alu_ready | mem_ready;
    win_dest_c = alu_ready ? alu_dest : mem_dest;
    win_data_c = alu_ready ? alu_data : mem_data;
  end

  // Registered write port and round-robin history; dest/data hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      write_en   <= 1'b0;
      write_dest <= '0;
      write_data <= '0;
      last_grant <= GNT_MEM;
    end else begin
      write_en <= xfer_c;
      if (xfer_c) begin
        write_dest <= win_dest_c;
        write_data <= win_data_c;
        last_grant <= alu_ready ? GNT_ALU : GNT_MEM;
      end
    end
  end

  gpr_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en      (issue_valid),
    .set_addr    (issue_dest),
    .clr_en      (write_en),
    .clr_addr    (write_dest),
    .chk_addr_1  (chk_addr_1),
    .chk_addr_2  (chk_addr_2),
    .chk_hit_1_c (hit_1_c),
    .chk_hit_2_c (hit_2_c),
    .pending     (pending)
  );

  // Decode-side hazard flags
  always_comb begin
    issue_conflict = pending[issue_dest];
    stall          = hit_1_c | hit_2_c | issue_conflict;
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Randomized and directed bench for gpr_wb_arbiter against a cycle-level reference model.
module tb_gpr_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, issue_valid;
  logic [2:0]  alu_dest, mem_dest, issue_dest, chk_addr_1, chk_addr_2;
  logic [15:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, issue_conflict, stall, write_en;
  logic [2:0]  write_dest;
  logic [15:0] write_data;
  logic [7:0]  pending;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit          m_known = 1'b0;
  bit          m_we;
  logic [2:0]  m_wd;
  logic [15:0] m_wdata;
  logic [7:0]  m_pend;
  bit          m_last_alu;
  bit          g_alu, g_mem;

  always #5 clk = ~clk;

  gpr_wb_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .alu_valid      (alu_valid),
    .alu_dest       (alu_dest),
    .alu_data       (alu_data),
    .alu_ready      (alu_ready),
    .mem_valid      (mem_valid),
    .mem_dest       (mem_dest),
    .mem_data       (mem_data),
    .mem_ready      (mem_ready),
    .issue_valid    (issue_valid),
    .issue_dest     (issue_dest),
    .issue_conflict (issue_conflict),
    .chk_addr_1     (chk_addr_1),
    .chk_addr_2     (chk_addr_2),
    .stall          (stall),
    .write_en       (write_en),
    .write_dest     (write_dest),
    .write_data     (write_data),
    .pending        (pending)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check registered state, drive inputs, check combinational
  // outputs, then advance the model to what the next edge should produce.
  task automatic step(input bit r, input bit av, input logic [2:0] ad, input logic [15:0] adt,
                      input bit mv, input logic [2:0] md, input logic [15:0] mdt,
                      input bit iv, input logic [2:0] id, input logic [2:0] c1, input logic [2:0] c2);
    logic [7:0] nxt;
    @(negedge clk);
    if (m_known) begin
      chk("write_en",   32'(write_en),   32'(m_we));
      chk("write_dest", 32'(write_dest), 32'(m_wd));
      chk("write_data", 32'(write_data), 32'(m_wdata));
      chk("pending",    32'(pending),    32'(m_pend));
    end
    rst = r; alu_valid = av; alu_dest = ad; alu_data = adt;
    mem_valid = mv; mem_dest = md; mem_data = mdt;
    issue_valid = iv; issue_dest = id; chk_addr_1 = c1; chk_addr_2 = c2;
    #1;
    g_alu = av && (!mv || !m_last_alu);
    g_mem = mv && !g_alu;
    if (m_known) begin
      chk("alu_ready",      32'(alu_ready),      32'(g_alu));
      chk("mem_ready",      32'(mem_ready),      32'(g_mem));
      chk("issue_conflict", 32'(issue_conflict), 32'(m_pend[id]));
      chk("stall",          32'(stall),          32'(m_pend[c1] | m_pend[c2] | m_pend[id]));
    end
    if (r) begin
      m_known = 1'b1; m_we = 1'b0; m_wd = '0; m_wdata = '0; m_pend = '0; m_last_alu = 1'b0;
    end else begin
      nxt = m_pend;
      if (m_we) nxt[m_wd] = 1'b0;
      if (iv)   nxt[id]   = 1'b1;
      m_pend = nxt;
      m_we = g_alu | g_mem;
      if (g_alu) begin m_wd = ad; m_wdata = adt; m_last_alu = 1'b1; end
      else if (g_mem) begin m_wd = md; m_wdata = mdt; m_last_alu = 1'b0; end
    end
  endtask

  task automatic idle(input bit r, input logic [2:0] c1);
    step(r, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 3'd0, c1, 3'd0);
  endtask

  task automatic post();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          a_hold = 1'b0, b_hold = 1'b0;
    logic [2:0]  a_d = '0, b_d = '0;
    logic [15:0] a_x = '0, b_x = '0;

    // Reset then idle
    idle(1, 3'd0);
    idle(1, 3'd0);
    idle(0, 3'd0);
    chk("idle_alu_ready", 32'(alu_ready), 32'd0);
    chk("idle_mem_ready", 32'(mem_ready), 32'd0);
    post();
    chk("idle_we",   32'(write_en), 32'd0);
    chk("idle_pend", 32'(pending),  32'd0);

    // Single ALU request
    step(0, 1, 3'd3, 16'hBEEF, 0, 3'd0, 16'h0, 0, 3'd0, 3'd0, 3'd0);
    chk("single_ready", 32'(alu_ready), 32'd1);
    post();
    chk("single_we",   32'(write_en),   32'd1);
    chk("single_dest", 32'(write_dest), 32'd3);
    chk("single_data", 32'(write_data), 32'hBEEF);
    idle(0, 3'd0);
    post();
    chk("single_we_off", 32'(write_en), 32'd0);

    // Contention after reset: ALU, MEM, ALU, MEM
    idle(1, 3'd0);
    step(0, 1, 3'd1, 16'h1111, 1, 3'd5, 16'h5555, 0, 3'd0, 3'd0, 3'd0);
    chk("cont_g0", 32'(alu_ready), 32'd1);
    post(); chk("cont_wd0", 32'(write_dest), 32'd1);
    step(0, 1, 3'd2, 16'h2222, 1, 3'd5, 16'h5555, 0, 3'd0, 3'd0, 3'd0);
    chk("cont_g1", 32'(mem_ready), 32'd1);
    post(); chk("cont_wd1", 32'(write_dest), 32'd5);
    step(0, 1, 3'd2, 16'h2222, 1, 3'd6, 16'h6666, 0, 3'd0, 3'd0, 3'd0);
    chk("cont_g2", 32'(alu_ready), 32'd1);
    post(); chk("cont_wd2", 32'(write_dest), 32'd2);
    step(0, 1, 3'd3, 16'h3333, 1, 3'd6, 16'h6666, 0, 3'd0, 3'd0, 3'd0);
    chk("cont_g3", 32'(mem_ready), 32'd1);
    post(); chk("cont_wd3", 32'(write_dest), 32'd6);

    // Scoreboard: issue dest 4, MEM writeback of 4 in cycle 3
    step(0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 1, 3'd4, 3'd0, 3'd0);
    post(); chk("sb_pend", 32'(pending), 32'h10);
    idle(0, 3'd4);
    chk("sb_stall1", 32'(stall), 32'd1);
    idle(0, 3'd4);
    step(0, 0, 3'd0, 16'h0, 1, 3'd4, 16'h4444, 0, 3'd0, 3'd4, 3'd0);
    chk("sb_mem_ready", 32'(mem_ready), 32'd1);
    idle(0, 3'd4);
    chk("sb_stall4", 32'(stall), 32'd1);
    idle(0, 3'd4);
    chk("sb_pend5",  32'(pending), 32'd0);
    chk("sb_stall5", 32'(stall),   32'd0);

    // Set/clear collision on register 2
    step(0, 1, 3'd2, 16'h00AA, 0, 3'd0, 16'h0, 0, 3'd0, 3'd0, 3'd0);
    step(0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 1, 3'd2, 3'd0, 3'd0);
    post(); chk("coll_p2", 32'(pending[2]), 32'd1);

    // Reset mid-operation drops the accepted write and restores last_grant=MEM
    step(0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 1, 3'd5, 3'd0, 3'd0);
    step(1, 1, 3'd7, 16'h7777, 0, 3'd0, 16'h0, 0, 3'd0, 3'd0, 3'd0);
    post();
    chk("rst_we",   32'(write_en), 32'd0);
    chk("rst_pend", 32'(pending),  32'd0);
    step(0, 1, 3'd1, 16'h0101, 1, 3'd2, 16'h0202, 0, 3'd0, 3'd0, 3'd0);
    chk("rst_tie_alu", 32'(alu_ready), 32'd1);
    post(); chk("rst_tie_dest", 32'(write_dest), 32'd1);

    // Random traffic with producers holding requests until accepted
    repeat (600) begin
      if (!a_hold && ($urandom_range(0, 1) == 0)) begin
        a_hold = 1'b1; a_d = 3'($urandom); a_x = 16'($urandom);
      end
      if (!b_hold && ($urandom_range(0, 1) == 0)) begin
        b_hold = 1'b1; b_d = 3'($urandom); b_x = 16'($urandom);
      end
      step(($urandom_range(0, 63) == 0), a_hold, a_d, a_x, b_hold, b_d, b_x,
           ($urandom_range(0, 3) == 0), 3'($urandom), 3'($urandom), 3'($urandom));
      if (g_alu) a_hold = 1'b0;
      if (g_mem) b_hold = 1'b0;
    end
    idle(0, 3'd0);
    idle(0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gpr_wb_arbiter.md
# gpr_wb_arbiter

Writeback arbiter and hazard scoreboard for the 8 x 16-bit general-purpose register file. Two producers share the file's single write port: the ALU writeback path and the memory-load writeback path. The block grants one producer per cycle using round-robin and drives a registered write port into the register file. It also keeps a per-register pending bit, so the decode stage can stall on read-after-write and write-after-write hazards.

## Interface
Parameters:
- DATA_W, 16, register data width
- ADDR_W, 3, register index width
- NREG, 8, register count; fixed to 2**ADDR_W

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU writeback request
- alu_dest  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  load writeback request
- mem_dest  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  load request accepted this cycle
- issue_valid  in  1  decode issues an instruction that writes issue_dest
- issue_dest  in  ADDR_W  destination of the issued instruction
- issue_conflict  out  1  pending[issue_dest], combinational (WAW hazard)
- chk_addr_1, chk_addr_2  in  ADDR_W  source operands under decode
- stall  out  1  pending[chk_addr_1] | pending[chk_addr_2] | issue_conflict, combinational
- write_en  out  1  register-file write enable, registered
- write_dest  out  ADDR_W  register-file write index, registered
- write_data  out  DATA_W  register-file write data, registered
- pending  out  NREG  scoreboard bit vector, registered

## Operation
- Handshake: a transfer occurs when valid && ready are both high.
  - valid must not depend on ready.
  - ready may depend on valid.
  - Once a producer raises valid, it holds valid, dest and data stable until accepted.
- Grant, combinational, at most one per cycle:
  - Only one producer valid: that producer is granted.
  - Both valid: the producer not granted most recently wins.
  - Neither valid: no grant, both ready low.
- last_grant register:
  - Updates only on a transfer.
  - Resets to MEM, so the ALU wins the first tie.
- Write port: on a transfer, the next edge loads write_en=1, write_dest and write_data from the winning producer. With no transfer, write_en=0; write_dest and write_data hold their values.
- Scoreboard, next-state per bit i:
  - Set when issue_valid && issue_dest==i.
  - Cleared when write_en && write_dest==i (the same edge at which the register file commits).
  - Simultaneous set and clear on the same bit: set wins, because a new producer supersedes the completing one.
- issue_valid while issue_conflict is high is a protocol error by decode. The pending bit stays set, and no error is latched.
- Writeback to a register whose pending bit is clear is legal. The write proceeds and the bit stays clear.
- Reset values: write_en=0, write_dest=0, write_data=0, pending=0, last_grant=MEM.
  - Reset mid-operation drops any accepted but uncommitted write.
  - Producers must re-present requests after reset.

## Timing
- Acceptance to register-file commit:
  - Transfer in cycle N.
  - write_en high during cycle N+1.
  - Register updated and pending bit cleared at the end-of-cycle-N+1 edge.
- stall remains high through cycle N+1. The first cycle in which a consumer can read the new value without stall is N+2.
- Issue to pending: issue_valid in cycle M makes pending high from cycle M+1.
- Throughput: one writeback per cycle. Under continuous contention from both producers, grants alternate ALU, MEM, ALU, and so on.
- No combinational path from write_* to any ready signal.

## Structure
- Package gpr_pkg holds:
  - DATA_W, ADDR_W, NREG.
  - typedef wb_req_t {logic [ADDR_W-1:0] dest; logic [DATA_W-1:0] data;}.
  - enum grant_t {GNT_ALU, GNT_MEM}.
- Sub-module gpr_scoreboard holds the NREG pending bits. It has:
  - set port: issue_valid, issue_dest.
  - clear port: write_en, write_dest.
  - two check ports.
- The top level holds the arbiter, last_grant and the write-port registers.

## Test plan
- Reset then idle → write_en=0, pending=8'h00, alu_ready=mem_ready=0.
- Single request: alu_valid, dest=3, data=16'hBEEF in cycle 0 → alu_ready=1 in cycle 0; write_en=1, write_dest=3, write_data=16'hBEEF in cycle 1; write_en=0 in cycle 2.
- Contention after reset: both valid for 4 cycles, with ALU dests 1,2 and MEM dests 5,6 → grants ALU,MEM,ALU,MEM; write_dest sequence 1,5,2,6.
- Scoreboard:
  - Step 1: issue dest=4 in cycle 0 → pending=8'h10 from cycle 1; chk_addr_1=4 gives stall=1.
  - Step 2: MEM writeback dest=4 accepted in cycle 3 → stall still 1 in cycle 4; pending=0 and stall=0 in cycle 5.
- Set/clear collision: write_en with write_dest=2 in the same cycle as issue_valid with issue_dest=2 → pending[2] stays 1.
- Reset mid-operation: ALU transfer in cycle N, rst high in cycle N → write_en=0 in cycle N+1, pending=0, last_grant=MEM.
